gpio_ones_counter: RTL and testbench
====================================

// Module: gpio_ones_counter
// PURPOSE
//  Downstream consumer of the A1<<A2 multiply stage in the GPIO emulator.
//  - Accepts the 49-bit result over a valid/ready handshake.
//  - Counts set bits of the low 32-bit word serially, BITS_PER_CLK bits per clock.
//  - Flags overflow when any bit of result[48:32] is set.
//  - Presents count, word and overflow to the bus read mux; keeps a 16-bit completed-op count for gpio_out.
// PARAMETERS
//  RES_W         49  width of incoming result
//  WORD_W        32  width of counted word, result[WORD_W-1:0]
//  BITS_PER_CLK  1   bits examined per SHIFT cycle; legal 1,2,4,8; must divide WORD_W
//  CNT_W         24  width of out_count, zero-extended
//  OPS_W         16  width of ops_count
// PORTS
//  clk           in   1        clock, all state changes on posedge
//  n_reset       in   1        asynchronous, active-low reset
//  clear         in   1        sync abort; driven by a write to control reg 0x3A0
//  in_valid      in   1        result available from multiply stage
//  in_ready      out  1        block can accept a result
//  in_data       in   RES_W    multiply result
//  out_valid     out  1        count complete, outputs stable
//  out_ready     in   1        consumer has taken the result
//  out_count     out  CNT_W    number of ones in in_data[WORD_W-1:0]
//  out_word      out  WORD_W   in_data[WORD_W-1:0] as accepted
//  out_overflow  out  1        |in_data[RES_W-1:WORD_W] as accepted
//  busy          out  1        high in SHIFT and HOLD
//  ops_count     out  OPS_W    completed handshakes, wraps to 0
// BEHAVIOUR
//  - Reset: all outputs and registers 0 except in_ready=1; state IDLE.
//    Reset asserted mid-operation discards the operation immediately.
//  - Handshakes: transfer happens on a posedge with valid&ready both high.
//    in_ready=1 only in IDLE; out_valid=1 only in HOLD.
//  - IDLE: on in_valid, latch the following and go to SHIFT:
//    - shift reg <= in_data[WORD_W-1:0]; out_word <= same value
//    - out_overflow <= |in_data[RES_W-1:WORD_W]
//    - count <= 0; remaining <= WORD_W/BITS_PER_CLK
//  - SHIFT, each clock:
//    - count += popcount(shift[BITS_PER_CLK-1:0])
//    - shift >>= BITS_PER_CLK; remaining--
//    - when remaining reaches 0, go to HOLD.
//    - Fixed latency: out_valid rises exactly WORD_W/BITS_PER_CLK clocks after the accept edge.
//  - HOLD: out_count/out_word/out_overflow held stable.
//    On out_ready: ops_count++ (wraps FFFF->0) and go to IDLE.
//    out_valid drops and in_ready rises on the same edge.
//  - Back-to-back: in_valid during HOLD is not accepted, even when out_ready is high;
//    it is accepted on the first IDLE edge. Minimum issue interval is K+2 clocks, K=WORD_W/BITS_PER_CLK.
//  - clear: priority over everything. Next edge forces IDLE, clears out_count/out_word/out_overflow,
//    and drops out_valid. No handshake completes and ops_count is unchanged.
//    clear together with in_valid in IDLE: the input is not accepted.
//  - Count arithmetic: max count WORD_W fits CNT_W; no saturation required.
//    Upper bits of out_count are always 0.
//  - out_* change only on the accept edge, in SHIFT (count only), or on clear/reset.
//    Outputs are registered; there is no combinational path from in_* to out_*.
// TESTING
//  1. Reset pulse -> out_* = 0, busy=0, ops_count=0, in_ready=1 on the first edge after release.
//  2. in_data=49'h0_FFFF_FFFF, BPC=1 -> out_valid exactly 32 clocks after accept; count=32, word=FFFFFFFF, ovf=0.
//  3. in_data=49'h1_0000_0005 -> count=2, word=00000005, ovf=1; in_data=0 -> count=0, ovf=0.
//  4. out_ready low 10 clocks in HOLD with in_valid held high -> outputs stable, in_ready=0;
//     on handshake ops_count 0->1, next input accepted one edge later.
//  5. clear asserted at SHIFT cycle 5 -> IDLE next edge, out_valid never rises, ops_count unchanged;
//     repeat with n_reset low mid-SHIFT -> everything 0 immediately.
//  6. BPC=4 instance, data 0xAAAAAAAA -> count=16 after 8 clocks;
//     preload ops_count=FFFF, one handshake -> ops_count=0000.

Source files
------------

// File: rtl/gpio_ones_counter.sv
// Serial ones-counter for the multiply-stage result: accepts a word, counts its set bits
// BITS_PER_CLK at a time, then holds count/word/overflow until the consumer takes them.
module gpio_ones_counter #(
    parameter int RES_W        = 49,
    parameter int WORD_W       = 32,
    parameter int BITS_PER_CLK = 1,
    parameter int CNT_W        = 24,
    parameter int OPS_W        = 16
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RES_W-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic [WORD_W-1:0] out_word,
    output logic              out_overflow,
    output logic              busy,
    output logic [OPS_W-1:0]  ops_count
);

    localparam int K     = WORD_W / BITS_PER_CLK;
    localparam int REM_W = $clog2(K + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t            state;
    logic [WORD_W-1:0] shift_reg;
    logic [REM_W-1:0]  remaining;
    logic [CNT_W-1:0]  chunk_ones;

    // Ones in the slice of the shift register consumed this cycle.
    always_comb begin
        chunk_ones = '0;
        for (int i = 0; i < BITS_PER_CLK; i++) begin
            chunk_ones = chunk_ones + CNT_W'(shift_reg[i]);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state        <= IDLE;
            shift_reg    <= '0;
            remaining    <= '0;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_count    <= '0;
            out_word     <= '0;
            out_overflow <= 1'b0;
            busy         <= 1'b0;
            ops_count    <= '0;
        end else if (clear) begin
            // Abort: no handshake completes, so ops_count is left alone.
            state        <= IDLE;
            shift_reg    <= '0;
            remaining    <= '0;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_count    <= '0;
            out_word     <= '0;
            out_overflow <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_reg    <= in_data[WORD_W-1:0];
                        out_word     <= in_data[WORD_W-1:0];
                        out_overflow <= |in_data[RES_W-1:WORD_W];
                        out_count    <= '0;
                        remaining    <= REM_W'(K);
                        in_ready     <= 1'b0;
                        busy         <= 1'b1;
                        state        <= SHIFT;
                    end
                end
                SHIFT: begin
                    out_count <= out_count + chunk_ones;
                    shift_reg <= shift_reg >> BITS_PER_CLK;
                    remaining <= remaining - 1'b1;
                    if (remaining == REM_W'(1)) begin
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    // Input is never accepted here; in_ready rises only as we return to IDLE.
                    if (out_ready) begin
                        ops_count <= ops_count + 1'b1;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_ones_counter.sv
// Directed + randomized bench for gpio_ones_counter: a 1-bit/clk instance and a
// 4-bit/clk instance with a narrow op counter so wrap-around is reachable.
module tb_gpio_ones_counter;

    localparam int K1 = 32;
    localparam int K4 = 8;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;

    logic        clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [48:0] in_data = '0;
    logic        in_ready, out_valid, out_overflow, busy;
    logic [23:0] out_count;
    logic [31:0] out_word;
    logic [15:0] ops_count;

    logic        clear4 = 1'b0, in_valid4 = 1'b0, out_ready4 = 1'b0;
    logic [48:0] in_data4 = '0;
    logic        in_ready4, out_valid4, out_overflow4, busy4;
    logic [23:0] out_count4;
    logic [31:0] out_word4;
    logic [3:0]  ops_count4;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] exp_ops = '0;
    logic [3:0]  exp_ops4 = '0;

    always #5 clk = ~clk;

    gpio_ones_counter dut (
        .clk(clk), .n_reset(n_reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count), .out_word(out_word), .out_overflow(out_overflow),
        .busy(busy), .ops_count(ops_count)
    );

    gpio_ones_counter #(.BITS_PER_CLK(4), .OPS_W(4)) dut4 (
        .clk(clk), .n_reset(n_reset), .clear(clear4),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_count(out_count4), .out_word(out_word4), .out_overflow(out_overflow4),
        .busy(busy4), .ops_count(ops_count4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [48:0] rand49();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[48:0];
    endfunction

    // Reference: the result is simply the popcount of the low word and an OR of the high part.
    task automatic run_op(input logic [48:0] d);
        int lat;
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("accept_busy", busy, 1);
        lat = 0;
        for (int n = 1; n <= K1 + 5; n++) begin
            tick();
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        check("latency", lat, K1);
        check("count", out_count, $countones(d[31:0]));
        check("word", out_word, d[31:0]);
        check("ovf", out_overflow, |d[48:32]);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_ops = exp_ops + 1'b1;
        check("ops", ops_count, exp_ops);
        check("ready_after", {out_valid, in_ready, busy}, 3'b010);
        $display("op data=%h count=%0d ovf=%0d ops=%0d", d, out_count, out_overflow, ops_count);
    endtask

    task automatic run_op4(input logic [48:0] d);
        int lat;
        in_data4  = d;
        in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        lat = 0;
        for (int n = 1; n <= K4 + 5; n++) begin
            tick();
            if (out_valid4) begin
                lat = n;
                break;
            end
        end
        check("latency4", lat, K4);
        check("count4", out_count4, $countones(d[31:0]));
        check("word4", out_word4, d[31:0]);
        check("ovf4", out_overflow4, |d[48:32]);
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
        exp_ops4 = exp_ops4 + 1'b1;
        check("ops4", ops_count4, exp_ops4);
        $display("op4 data=%h count=%0d ops=%0d", d, out_count4, ops_count4);
    endtask

    initial begin
        logic [48:0] d, d2;
        logic        saw_valid;

        // Reset
        #12;
        check("rst_outs", {out_valid, out_count, out_word, out_overflow, busy, ops_count}, 0);
        n_reset = 1'b1;
        tick();
        check("rst_ready", in_ready, 1);
        check("rst_idle", {busy, out_valid, ops_count, out_count}, 0);
        $display("reset released");

        // Directed corner values, then random
        run_op(49'h0_FFFF_FFFF);
        run_op(49'h1_0000_0005);
        run_op(49'h0);
        for (int i = 0; i < 12; i++) run_op(rand49());

        // Stall in HOLD with in_valid asserted
        d  = rand49();
        d2 = rand49();
        in_data = d; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (K1) tick();
        check("stall_valid", out_valid, 1);
        in_data = d2; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_hold", {out_valid, in_ready, out_word, out_count},
                  {1'b1, 1'b0, d[31:0], 24'($countones(d[31:0]))});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_ops = exp_ops + 1'b1;
        check("stall_ops", ops_count, exp_ops);
        check("stall_idle", {in_ready, busy}, 2'b10);
        tick();
        in_valid = 1'b0;
        check("b2b_accept", {busy, out_word}, {1'b1, d2[31:0]});
        repeat (K1) tick();
        check("b2b_count", {out_valid, out_count}, {1'b1, 24'($countones(d2[31:0]))});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_ops = exp_ops + 1'b1;
        check("b2b_ops", ops_count, exp_ops);
        $display("stall/back-to-back done ops=%0d", ops_count);

        // clear mid-SHIFT
        in_data = 49'h1_FFFF_FFFF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_state", {busy, in_ready, out_valid, out_overflow}, 4'b0100);
        check("clr_data", {out_count, out_word}, 0);
        saw_valid = 1'b0;
        repeat (K1 + 3) begin
            tick();
            saw_valid |= out_valid;
        end
        check("clr_novalid", saw_valid, 0);
        check("clr_ops", ops_count, exp_ops);
        clear = 1'b1; in_valid = 1'b1; in_data = 49'h5;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        check("clr_noaccept", {busy, in_ready, out_word}, {1'b0, 1'b1, 32'h0});
        $display("clear checks done");

        // Asynchronous reset mid-SHIFT
        in_data = 49'h1_0000_00FF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        #2 n_reset = 1'b0;
        #1;
        check("arst_outs", {out_valid, out_count, out_word, out_overflow, busy, ops_count}, 0);
        check("arst_ready", in_ready, 1);
        exp_ops  = '0;
        exp_ops4 = '0;
        #3 n_reset = 1'b1;
        tick();
        run_op(rand49());
        $display("async reset checks done");

        // 4-bit/clk instance, including op counter wrap
        run_op4(49'h0_AAAA_AAAA);
        for (int i = 0; i < 16; i++) run_op4(rand49());
        check("wrap4", ops_count4, 4'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
